down_counter_timer: RTL

// Loadable down-counter timer and the counting-direction counterpart of the

---
 rtl/down_counter_timer_if.sv | 36 +++
 rtl/down_counter_timer.sv | 79 +++++++
 2 files changed

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for the loadable down-counter timer; the master drives
// the strobes and load value, the slave (timer) returns count and status.
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic [WIDTH-1:0] counter_out;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output enable,
    output load,
    output load_value,
    output auto_reload,
    input  counter_out,
    input  tc,
    input  busy,
    input  done
  );

  modport slave (
    input  enable,
    input  load,
    input  load_value,
    input  auto_reload,
    output counter_out,
    output tc,
    output busy,
    output done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: one-shot or periodic terminal-count pulse; count,
// tc and state update one clock after load/enable; no backpressure, enable=0 freezes.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  down_counter_timer_if.slave  tmr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q,     tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (tmr.load) begin
      // A zero load parks the timer in IDLE rather than producing a tc.
      reload_d = tmr.load_value;
      count_d  = tmr.load_value;
      state_d  = (tmr.load_value != CNT_ZERO) ? ST_RUN : ST_IDLE;
    end else if (tmr.enable) begin
      case (state_q)
        ST_RUN: begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else if (count_q == CNT_ONE) begin
            count_d = CNT_ZERO;
            tc_d    = 1'b1;
            state_d = tmr.auto_reload ? ST_RUN : ST_DONE;
          end else if (tmr.auto_reload) begin
            // The zero cycle is the extra period slot: N+1 enabled cycles per tc.
            count_d = reload_q;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign tmr.counter_out = count_q;
  assign tmr.tc          = tc_q;
  assign tmr.busy        = (state_q == ST_RUN);
  assign tmr.done        = (state_q == ST_DONE);

endmodule
